// File: rtl/tiny1_soc_top.sv
// tiny1_soc_top
//   Board-level block for the LED demo: an 8-bit display register on the
//   LEDs, a heartbeat prescaler, an 8N1 UART receiver and an 8N1 UART
//   transmitter that echoes each received byte.
//
//   After reset the LEDs show a binary count that advances every
//   2^PRESC_BITS cycles. Each correctly framed byte on RXD is latched onto
//   the LEDs, which then stay frozen. The byte is echoed on TXD if the
//   transmitter is idle.
//
// Parameters
//   BAUD_DIV   clock cycles per UART bit (4 or more)
//   PRESC_BITS heartbeat prescaler width
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active high
//   RXD         UART receive line, idle high, asynchronous to clk
//   TXD         UART transmit line, idle high, registered
//   LED1..LED8  display register bits 0..7, registered
//
// RX state | meaning
// ---------+---------------------------------------------------------
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sample 8 data bits, one per bit period, LSB first
// RX_STOP  | sample stop bit; high delivers the byte, low discards it
//
// TX state | meaning
// ---------+---------------------------------------------------------
// TX_IDLE  | line high, waiting for a received byte to echo
// TX_START | start bit (0) for one bit period
// TX_DATA  | 8 data bits, LSB first, one bit period each
// TX_STOP  | stop bit (1) for one bit period
module tiny1_soc_top #(
    parameter int BAUD_DIV   = 104,
    parameter int PRESC_BITS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic RXD,
    output logic TXD,
    output logic LED1,
    output logic LED2,
    output logic LED3,
    output logic LED4,
    output logic LED5,
    output logic LED6,
    output logic LED7,
    output logic LED8
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------------------------------------------------------
    // Display register and heartbeat
    // ---------------------------------------------------------------
    logic [PRESC_BITS-1:0] presc_q, presc_d;
    logic [7:0]            disp_q;
    logic                  hold_q;       // 0 = COUNT, 1 = HOLD
    logic                  presc_wrap;

    logic [7:0]            rx_data_q;
    logic                  rx_valid_q;

    assign presc_d    = presc_q + PRESC_BITS'(1);
    assign presc_wrap = (presc_q == '1);  // next value is 0

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            disp_q  <= 8'h00;
            hold_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            // A received byte wins over a heartbeat step in the same cycle.
            if (rx_valid_q) begin
                disp_q <= rx_data_q;
                hold_q <= 1'b1;
            end else if (!hold_q && presc_wrap) begin
                disp_q <= disp_q + 8'd1;
            end
        end
    end

    assign {LED8, LED7, LED6, LED5, LED4, LED3, LED2, LED1} = disp_q;

    // ---------------------------------------------------------------
    // RX synchroniser and falling-edge detect
    // ---------------------------------------------------------------
    // The synchroniser and edge history reset low so that a line held low
    // from reset never looks like a falling edge, and a line that is high
    // just shows a rising edge.
    logic rx_meta_q, rxs_q, rxs_prev_q;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b0;
            rxs_q      <= 1'b0;
            rxs_prev_q <= 1'b0;
        end else begin
            rx_meta_q  <= RXD;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign rx_fall = rxs_prev_q & ~rxs_q;

    // ---------------------------------------------------------------
    // RX state machine
    // ---------------------------------------------------------------
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (!rxs_q) begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= BAUD_LAST;
                            rx_bit_q   <= 3'd0;
                        end else begin
                            rx_state_q <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rxs_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= BAUD_LAST;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) begin
                        // A low stop bit is a framing error: drop the byte.
                        if (rxs_q) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                        end
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // TX state machine
    // ---------------------------------------------------------------
    tx_state_t        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       tx_shift_q;
    logic             txd_q;
    logic             tx_busy;
    logic             tx_accept;

    assign tx_busy   = (tx_state_q != TX_IDLE);
    // Echo only when idle; a byte arriving mid-echo still updates the LEDs.
    assign tx_accept = rx_valid_q && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    txd_q <= 1'b1;
                    if (tx_accept) begin
                        tx_state_q <= TX_START;
                        tx_cnt_q   <= BAUD_LAST;
                        tx_shift_q <= rx_data_q;
                        txd_q      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= BAUD_LAST;
                        tx_bit_q   <= 3'd0;
                        txd_q      <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= BAUD_LAST;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            txd_q      <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            txd_q      <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CNT_W'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TXD = txd_q;

endmodule

// File: tb/tb_tiny1_soc_top.sv
module tb_tiny1_soc_top;

    localparam int B = 104;
    localparam int H = 52;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, default parameters
    logic       rst;
    logic       RXD;
    logic       TXD;
    logic [7:0] led;

    // second instance, PRESC_BITS = 2
    logic       rst6;
    logic       rxd6;
    logic       txd6;
    logic [7:0] led6;

    tiny1_soc_top #(.BAUD_DIV(104), .PRESC_BITS(10)) u_dut (
        .clk (clk), .rst (rst), .RXD (RXD), .TXD (TXD),
        .LED1(led[0]), .LED2(led[1]), .LED3(led[2]), .LED4(led[3]),
        .LED5(led[4]), .LED6(led[5]), .LED7(led[6]), .LED8(led[7])
    );

    tiny1_soc_top #(.BAUD_DIV(104), .PRESC_BITS(2)) u_dut6 (
        .clk (clk), .rst (rst6), .RXD (rxd6), .TXD (txd6),
        .LED1(led6[0]), .LED2(led6[1]), .LED3(led6[2]), .LED4(led6[3]),
        .LED5(led6[4]), .LED6(led6[5]), .LED7(led6[6]), .LED8(led6[7])
    );

    int total = 0;
    int bad   = 0;

    // cycles since reset release; COUNT-mode reference is since/1024 mod 256
    int since = 0;
    always @(posedge clk) begin
        if (rst) since <= 0;
        else     since <= since + 1;
    end

    function automatic int hb_model(input int k);
        return (k / 1024) % 256;
    endfunction

    // background monitors: TXD-low cycles and LED change events
    int         txd_low = 0;
    int         led_chg = 0;
    logic [7:0] led_prev = 8'h00;
    always @(negedge clk) begin
        if (TXD !== 1'b1) txd_low = txd_low + 1;
        if (led !== led_prev) led_chg = led_chg + 1;
        led_prev = led;
    end

    task automatic check(input string nm, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stopb);
        RXD = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            RXD = data[i];
            tick(B);
        end
        RXD = stopb;
        tick(B);
        RXD = 1'b1;
    endtask

    task automatic capture_tx(input logic [7:0] exp, input string nm);
        int         n;
        int         w;
        logic [7:0] got;
        logic       stopb;
        n = 0;
        w = 0;
        got = 8'h00;
        while (TXD !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (TXD !== 1'b0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL %s_start: no start bit within %0d cycles", nm, n);
        end else begin
            while (TXD === 1'b0 && w < 2000) begin
                w++;
                @(negedge clk);
            end
            check({nm, "_start_width"}, w, B);
            repeat (H) @(negedge clk);
            got[0] = TXD;
            for (int i = 1; i < 8; i++) begin
                repeat (B) @(negedge clk);
                got[i] = TXD;
            end
            repeat (B) @(negedge clk);
            stopb = TXD;
            check({nm, "_data"}, got, exp);
            check({nm, "_stop"}, stopb, 1);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] led;
    } hb_vec_t;

    hb_vec_t hb[9];

    initial begin
        int k_now;
        int t0;
        int c0;

        hb[0] = '{0,    8'h00};
        hb[1] = '{1023, 8'h00};
        hb[2] = '{1024, 8'h01};
        hb[3] = '{1025, 8'h01};
        hb[4] = '{2047, 8'h01};
        hb[5] = '{2048, 8'h02};
        hb[6] = '{3071, 8'h02};
        hb[7] = '{3072, 8'h03};
        hb[8] = '{9000, 8'h08};

        rst  = 1'b1;
        RXD  = 1'b0;
        rst6 = 1'b1;
        rxd6 = 1'b1;
        tick(2);
        rst = 1'b0;

        // reset state and heartbeat with RXD held low
        check("rst_led", led, 8'h00);
        check("rst_txd", TXD, 1);
        t0 = txd_low;
        k_now = 0;
        for (int i = 0; i < 9; i++) begin
            tick(hb[i].k - k_now);
            k_now = hb[i].k;
            check($sformatf("hb_k%0d", hb[i].k), led, hb[i].led);
        end
        check("t1_txd_idle", txd_low - t0, 0);

        // valid byte 0xA5: latency, echo, freeze
        RXD = 1'b1;
        tick(200);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                tick(990);
                check("t2_led_early", (led == 8'hA5) ? 1 : 0, 0);
                tick(3);
                check("t2_led", led, 8'hA5);
            end
            capture_tx(8'hA5, "t2_echo");
        join
        c0 = led_chg;
        tick(20000);
        check("t2_freeze_led", led, 8'hA5);
        check("t2_freeze_chg", led_chg - c0, 0);

        // framing error: byte 0x3C with low stop bit
        rst = 1'b1;
        tick(1);
        check("t3_rst_led", led, 8'h00);
        check("t3_rst_txd", TXD, 1);
        rst = 1'b0;
        tick(100);
        t0 = txd_low;
        send_byte(8'h3C, 1'b0);
        tick(300);
        check("t3_led", led, hb_model(since));
        tick(1024);
        check("t3_count", led, hb_model(since));
        check("t3_txd_idle", txd_low - t0, 0);

        // 30-cycle glitch
        t0 = txd_low;
        RXD = 1'b0;
        tick(30);
        RXD = 1'b1;
        tick(1500);
        check("t4_led", led, hb_model(since));
        check("t4_txd_idle", txd_low - t0, 0);

        // reset in the middle of both an RX frame and a TX echo
        send_byte(8'h5A, 1'b1);
        RXD = 1'b0;
        tick(B);
        RXD = 1'b1;
        tick(B);
        RXD = 1'b0;
        tick(92);
        check("t5_pre_led", led, 8'h5A);
        check("t5_pre_txd_busy", (txd_low - t0 > 0) ? 1 : 0, 1);
        rst = 1'b1;
        RXD = 1'b1;
        tick(1);
        check("t5_rst_led", led, 8'h00);
        check("t5_rst_txd", TXD, 1);
        rst = 1'b0;
        t0 = txd_low;
        tick(1500);
        check("t5_no_partial", led, hb_model(since));
        check("t5_txd_idle", txd_low - t0, 0);
        fork
            send_byte(8'h81, 1'b1);
            capture_tx(8'h81, "t5_echo");
        join
        check("t5_led", led, 8'h81);

        // PRESC_BITS = 2 wrap
        rst6 = 1'b0;
        tick(1023);
        check("t6_k1023", led6, 8'hFF);
        tick(1);
        check("t6_k1024", led6, 8'h00);
        tick(3);
        check("t6_k1027", led6, 8'h00);
        tick(1);
        check("t6_k1028", led6, 8'h01);
        check("t6_txd", txd6, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
